// File: rtl/muldiv_unit_pkg.sv
// Types shared by the iterative multiply/divide unit and its users.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MduOp_MULT  = 2'd0,
        MduOp_MULTU = 2'd1,
        MduOp_DIV   = 2'd2,
        MduOp_DIVU  = 2'd3
    } MduOp;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } MduState;

    function automatic logic op_is_div(input MduOp op);
        return (op == MduOp_DIV) || (op == MduOp_DIVU);
    endfunction

    function automatic logic op_is_signed(input MduOp op);
        return (op == MduOp_MULT) || (op == MduOp_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing a HI/LO pair.
// One shift-add / restoring shift-subtract step per cycle on a shared
// 2*DATA_WIDTH accumulator, followed by a sign-fix cycle.
// Build option MULDIV_MULT_EN: when defined the multiply datapath is present;
// when undefined MULT/MULTU are rejected with o_unsupported.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  MduOp                  i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic                  o_divzero,
    output logic                  o_unsupported
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    MduState        r_state, w_next;
    logic           r_div, r_neg_q, r_neg_r, r_divzero, r_unsup;
    logic [W-1:0]   r_b, r_hi, r_lo;
    logic [2*W-1:0] r_acc;
    logic [CW-1:0]  r_cnt;

    logic           w_start_div, w_start_sgn, w_dz, w_reject;
    logic [W-1:0]   w_a_abs, w_b_abs, w_fix_hi, w_fix_lo;
    logic [W:0]     w_add_a, w_sum;
    logic [2*W-1:0] w_step;

    assign w_start_div = op_is_div(i_op);
    assign w_start_sgn = op_is_signed(i_op);
    assign w_dz        = w_start_div && (i_b == '0);
`ifdef MULDIV_MULT_EN
    assign w_reject    = 1'b0;
`else
    assign w_reject    = !w_start_div;
`endif
    // Magnitudes feed the unsigned core; signs are re-applied in FIX.
    assign w_a_abs = (w_start_sgn && i_a[W-1]) ? -i_a : i_a;
    assign w_b_abs = (w_start_sgn && i_b[W-1]) ? -i_b : i_b;

    // Shared W+1-bit adder: divide compares the shifted remainder (including
    // the bit shifted out of the top) against the divisor; multiply adds the
    // multiplicand into the upper half with carry.
`ifdef MULDIV_MULT_EN
    assign w_add_a = r_div ? r_acc[2*W-1:W-1] : {1'b0, r_acc[2*W-1:W]};
    assign w_sum   = r_div ? (w_add_a - {1'b0, r_b}) : (w_add_a + {1'b0, r_b});
`else
    assign w_add_a = r_acc[2*W-1:W-1];
    assign w_sum   = w_add_a - {1'b0, r_b};
`endif

    // One iteration of the shared shift register.
    always_comb begin
        w_step = {r_acc[2*W-2:0], 1'b0};
        if (r_div) begin
            if (!w_sum[W]) w_step = {w_sum[W-1:0], r_acc[W-2:0], 1'b1};
        end
`ifdef MULDIV_MULT_EN
        else if (r_acc[0]) w_step = {w_sum, r_acc[W-1:1]};
        else               w_step = {1'b0, r_acc[2*W-1:1]};
`endif
    end

    // Sign correction: quotient/remainder independently, product as a whole.
    always_comb begin
        w_fix_hi = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
        w_fix_lo = r_neg_q ? -r_acc[W-1:0]   : r_acc[W-1:0];
`ifdef MULDIV_MULT_EN
        if (!r_div && r_neg_q) {w_fix_hi, w_fix_lo} = -r_acc;
`endif
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (!i_reset) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic; divide-by-zero and rejected ops bypass RUN/FIX.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                w_next = IDLE;
                if (i_start) w_next = (w_dz || w_reject) ? DONE : RUN;
            end
            RUN:     if (r_cnt == CW'(W-1)) w_next = FIX;
            FIX:     w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: latch on accept, iterate in RUN, publish HI/LO entering DONE.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_div     <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_divzero <= 1'b0;
            r_unsup   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: if (i_start) begin
                    r_div   <= w_start_div;
                    r_neg_q <= w_start_sgn && (i_a[W-1] ^ i_b[W-1]);
                    r_neg_r <= w_start_sgn && w_start_div && i_a[W-1];
                    r_b     <= w_b_abs;
                    r_acc   <= {{W{1'b0}}, w_a_abs};
                    r_cnt   <= '0;
                    if (w_reject) begin
                        r_unsup   <= 1'b1;
                        r_divzero <= 1'b0;
                    end else if (w_dz) begin
                        r_hi      <= i_a;
                        r_lo      <= '1;
                        r_divzero <= 1'b1;
                        r_unsup   <= 1'b0;
                    end
                end
                RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + CW'(1);
                end
                FIX: begin
                    r_hi      <= w_fix_hi;
                    r_lo      <= w_fix_lo;
                    r_divzero <= 1'b0;
                    r_unsup   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (r_state == RUN) || (r_state == FIX);
    assign o_done    = (r_state == DONE);
    assign o_hi      = r_hi;
    assign o_lo      = r_lo;
    assign o_divzero = r_divzero;
`ifdef MULDIV_MULT_EN
    assign o_unsupported = 1'b0;
    logic w_unused_unsup;
    assign w_unused_unsup = r_unsup;
`else
    assign o_unsupported = r_unsup;
`endif

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the integer core. It executes MIPS-style MULT, MULTU, DIV and DIVU on DATA_WIDTH-bit operands and produces a HI/LO result pair. It sits beside the single-cycle ALU and serves the AluOp_DIV/AluOp_DIVU class of operations, plus multiply. Handshake is start/busy/done; the result is held until the next operation completes.

## Interface
- DATA_WIDTH, 32, operand and HI/LO width; even, ≥ 4.
- i_clock  in  1  single clock; all state updates on its rising edge.
- i_reset  in  1  reset, synchronous, active-low.
- i_start  in  1  request; sampled only when o_busy = 0.
- i_op  in  MduOp  operation: MduOp_MULT, MduOp_MULTU, MduOp_DIV or MduOp_DIVU.
- i_a  in  DATA_WIDTH  multiplicand / dividend.
- i_b  in  DATA_WIDTH  multiplier / divisor.
- o_busy  out  1  operation in progress; start is ignored.
- o_done  out  1  one-cycle pulse; results valid.
- o_hi  out  DATA_WIDTH  product upper half / remainder.
- o_lo  out  DATA_WIDTH  product lower half / quotient.
- o_divzero  out  1  the last completed op was a divide with i_b = 0; valid with o_done and held.
- o_unsupported  out  1  the last request was rejected (see Configuration); held.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + i_start: latch op and operands, take absolute values for signed ops, clear the iteration counter, go to RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. The counter ($clog2(DATA_WIDTH) bits) runs 0..DATA_WIDTH-1, then goes to FIX.
- FIX: apply the sign.
  - MULT: negate the 2·DATA_WIDTH product if the operand signs differ.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
- DONE: o_done = 1 for one cycle. With no i_start this cycle, go to IDLE.
- HI/LO registers update only on entry to DONE.
- Divide by zero (DIV or DIVU, i_b = 0): skip RUN and FIX and go straight to DONE.
  - lo = all ones, hi = i_a, o_divzero = 1.
- Signed overflow (DIV of most-negative by -1): lo = most-negative, hi = 0; no flag.
- Reset: state to IDLE. o_busy, o_done, o_divzero and o_unsupported = 0; o_hi = o_lo = 0. An operation in flight is discarded.

## Timing
- Start sampled at the edge ending cycle T.
- Normal op: RUN in cycles T+1..T+DATA_WIDTH, FIX in T+DATA_WIDTH+1, o_done in T+DATA_WIDTH+2. Latency is DATA_WIDTH+2 (34 at default).
- o_busy = 1 for cycles T+1..T+DATA_WIDTH+1 and 0 in the DONE cycle. A start in the DONE cycle is accepted, so ops run back-to-back with no bubble.
- Divide-by-zero or rejected op: o_done in T+1, o_busy never asserted.
- Start while o_busy = 1: ignored; no state change.
- Reset low has priority over every other input in the same cycle.

## Configuration
- MULDIV_MULT_EN defined: all four ops are supported; o_unsupported is tied 0.
- MULDIV_MULT_EN undefined: multiply datapath removed.
  - MULT/MULTU: o_done at T+1, o_unsupported = 1, o_hi/o_lo unchanged, o_divzero = 0.
  - Divide behaviour is identical in both configurations.

## Structure
- The types package gains:
  - MduOp enum: MduOp_MULT, MduOp_MULTU, MduOp_DIV, MduOp_DIVU.
  - MduState enum: IDLE, RUN, FIX, DONE.
- One flat module. Multiply and divide share one 2·DATA_WIDTH shift register and one DATA_WIDTH-bit adder/subtractor; no sub-module.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → at T+34: o_done = 1, hi = 0xFFFFFFFE, lo = 0x00000001; o_busy high T+1..T+33.
- MULT -3 × 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. DIV -7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 100 / 0 → at T+1: o_done = 1, o_divzero = 1, lo = 0xFFFFFFFF, hi = 0x00000064. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- Start pulsed at T+5 during busy → ignored; first result unchanged. Start during the DONE cycle → second op completes 34 cycles later with no gap.
- i_reset low at T+10 of a DIVU → next cycle all outputs 0, state IDLE, no o_done ever issued for that op.
- Build without MULDIV_MULT_EN: MULT 2×3 → T+1 o_done = 1, o_unsupported = 1, hi/lo retain previous values; DIVU 9/2 → lo = 4, hi = 1.
